// File: rtl/out_serial_port_pkg.sv
// Shared definitions for the serial output port: transmitter state encoding
// and 8N1 frame constants.
package out_serial_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

  // True when the given data bit index is the final one of a frame.
  function automatic logic is_last_bit(input logic [2:0] idx);
    return idx == 3'(DATA_BITS - 1);
  endfunction

endpackage

// File: rtl/out_serial_port_sync_fifo.sv
// Circular-buffer FIFO with a registered occupancy count; accept reports whether
// a push is taken, which includes pushing into a full FIFO that pops this cycle.
module out_serial_port_sync_fifo
  import out_serial_port_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DATA_BITS,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             accept
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_pop;

  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign accept = push && (!full || do_pop);
  assign dout   = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) wptr <= wptr + PTR_ONE;
      if (do_pop) rptr <= rptr + PTR_ONE;
      case ({accept, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; it is gated by accept so wdata is never
  // sampled when no push is taken.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= din;
  end

endmodule

// File: rtl/out_serial_port.sv
// CPU output stage: queues written bytes in a FIFO and drains them as 8N1
// serial frames on txd, with status flags for back-pressure.
module out_serial_port
  import out_serial_port_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int CW           = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [7:0]    wdata,
  output logic          txd,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  tx_state_t   state;
  tx_state_t   state_next;
  logic [BW-1:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        pop;
  logic        baud_last;
  logic        accept;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;

  out_serial_port_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS),
    .CW    (CW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (wr),
    .pop    (pop),
    .din    (wdata),
    .dout   (fifo_dout),
    .count  (count),
    .full   (full),
    .empty  (fifo_empty),
    .accept (accept)
  );

  assign empty     = fifo_empty;
  assign busy      = (state != ST_IDLE);
  assign baud_last = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: if (baud_last) state_next = ST_DATA;
      ST_DATA:  if (baud_last && is_last_bit(bit_idx)) state_next = ST_STOP;
      ST_STOP:  if (baud_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Baud counter restarts on every state change so each state owns whole bit slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == ST_IDLE || state_next != state || baud_last) baud_cnt <= '0;
      else                                                      baud_cnt <= baud_cnt + BAUD_ONE;

      if (state != ST_DATA) bit_idx <= '0;
      else if (baud_last)   bit_idx <= bit_idx + 3'd1;

      if (wr && !accept) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)                            shift <= fifo_dout;
    else if (state == ST_DATA && baud_last) shift <= {1'b0, shift[7:1]};
  end

  // txd is registered from the current state, so it trails the state by one
  // clock and has no combinational path from the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      txd <= IDLE_LEVEL;
    end else begin
      case (state)
        ST_START: txd <= START_BIT;
        ST_DATA:  txd <= shift[0];
        ST_STOP:  txd <= STOP_BIT;
        default:  txd <= IDLE_LEVEL;
      endcase
    end
  end

endmodule

// File: tb/tb_out_serial_port.sv
// Directed bench for out_serial_port with DEPTH=4, CLKS_PER_BIT=4: a table of
// hand-derived checkpoints for one frame plus sequences for the queue corners.
module tb_out_serial_port;

  localparam int DEPTH        = 4;
  localparam int CLKS_PER_BIT = 4;
  localparam int CW           = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr = 1'b0;
  logic [7:0]    wdata = 8'h00;
  logic          txd;
  logic          busy;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  out_serial_port #(
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CW           (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .wdata    (wdata),
    .txd      (txd),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  typedef struct {
    int            off;
    logic          txd;
    logic          busy;
    logic [CW-1:0] count;
    logic          empty;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    wr    = 1'b0;
    repeat (2) tick;
    reset = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr    = 1'b1;
    wdata = b;
    tick;
    wr    = 1'b0;
    wdata = 8'hxx;
  endtask

  // Receives one frame: s is the first cycle txd is seen low.
  task automatic rx_frame(output logic [7:0] b, output int s);
    int n;
    b = 8'h00;
    s = -1;
    n = 0;
    while (txd !== 1'b0 && n < 300) begin
      tick;
      n++;
    end
    if (txd !== 1'b0) begin
      chk("rx_start_timeout", 32'(txd), 0);
      return;
    end
    s = cyc;
    repeat (2) tick;
    chk("rx_start_bit", 32'(txd), 0);
    repeat (3) tick;
    b[0] = txd;
    for (int k = 1; k < 8; k++) begin
      repeat (4) tick;
      b[k] = txd;
    end
    repeat (4) tick;
    chk("rx_stop_bit", 32'(txd), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 20000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int busy_n;
    int tw;
    int s;
    int seen_low;
    int seen_busy;
    int n;
    logic [7:0] b;
    logic [7:0] exp_q [5];

    // Single-frame checkpoints for 0xA5 written at edge t (offsets from t).
    tbl.push_back(vec_t'{0,  1'b1, 1'b0, 4'd1, 1'b0});
    tbl.push_back(vec_t'{1,  1'b1, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{2,  1'b0, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{5,  1'b0, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{6,  1'b1, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{9,  1'b1, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{10, 1'b0, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{14, 1'b1, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{18, 1'b0, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{22, 1'b0, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{26, 1'b1, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{30, 1'b0, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{33, 1'b0, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{34, 1'b1, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{37, 1'b1, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{38, 1'b1, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{40, 1'b1, 1'b1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{41, 1'b1, 1'b0, 4'd0, 1'b1});

    // Reset values held for 20 cycles.
    do_reset;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("rst_txd@%0d", i), 32'(txd), 1);
      chk($sformatf("rst_busy@%0d", i), 32'(busy), 0);
      chk($sformatf("rst_empty@%0d", i), 32'(empty), 1);
      chk($sformatf("rst_count@%0d", i), 32'(count), 0);
      chk($sformatf("rst_ovf@%0d", i), 32'(overflow), 0);
      tick;
    end

    // Single byte 0xA5 against the checkpoint table.
    do_reset;
    write_byte(8'hA5);
    t = cyc;
    busy_n = 0;
    foreach (tbl[i]) begin
      while (cyc - t < tbl[i].off) begin
        tick;
        busy_n += int'(busy);
      end
      chk($sformatf("sb_txd@%0d", tbl[i].off), 32'(txd), 32'(tbl[i].txd));
      chk($sformatf("sb_busy@%0d", tbl[i].off), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("sb_count@%0d", tbl[i].off), 32'(count), 32'(tbl[i].count));
      chk($sformatf("sb_empty@%0d", tbl[i].off), 32'(empty), 32'(tbl[i].empty));
      chk($sformatf("sb_ovf@%0d", tbl[i].off), 32'(overflow), 0);
    end
    while (cyc - t < 60) begin
      tick;
      busy_n += int'(busy);
    end
    chk("sb_busy_cycles", 32'(busy_n), 40);

    // Burst of six writes into a four-deep FIFO.
    do_reset;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          wr    = 1'b1;
          wdata = 8'(k);
          tick;
          if (k == 1) t0 = cyc;
          if (k == 5) begin
            chk("burst_count_full", 32'(count), 4);
            chk("burst_full", 32'(full), 1);
            chk("burst_ovf_before", 32'(overflow), 0);
          end
        end
        wr    = 1'b0;
        wdata = 8'hxx;
        tick;
        chk("burst_ovf_set", 32'(overflow), 1);
        chk("burst_count_after_drop", 32'(count), 4);
      end
      begin
        int prev;
        logic [7:0] rb;
        int rs;
        prev = 0;
        for (int f = 0; f < 5; f++) begin
          rx_frame(rb, rs);
          chk($sformatf("burst_byte%0d", f), 32'(rb), 32'(f + 1));
          if (f == 0) chk("burst_first_latency", 32'(rs - t0), 2);
          else        chk($sformatf("burst_gap%0d", f), 32'(rs - prev), 41);
          prev = rs;
        end
      end
    join
    repeat (60) tick;
    chk("burst_empty_end", 32'(empty), 1);
    chk("burst_busy_end", 32'(busy), 0);
    chk("burst_ovf_sticky", 32'(overflow), 1);

    // Full FIFO accepting a write on the cycle the transmitter pops.
    do_reset;
    write_byte(8'hA0);
    write_byte(8'h11);
    write_byte(8'h82);
    write_byte(8'hC3);
    write_byte(8'h5A);
    chk("fp_count_filled", 32'(count), 4);
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick;
      n++;
    end
    chk("fp_idle_reached", 32'(busy), 0);
    chk("fp_full_at_pop", 32'(full), 1);
    write_byte(8'h77);
    chk("fp_count_kept", 32'(count), 4);
    chk("fp_ovf_clear", 32'(overflow), 0);
    chk("fp_busy_restart", 32'(busy), 1);
    exp_q[0] = 8'h11;
    exp_q[1] = 8'h82;
    exp_q[2] = 8'hC3;
    exp_q[3] = 8'h5A;
    exp_q[4] = 8'h77;
    for (int f = 0; f < 5; f++) begin
      rx_frame(b, s);
      chk($sformatf("fp_byte%0d", f), 32'(b), 32'(exp_q[f]));
    end
    chk("fp_ovf_final", 32'(overflow), 0);

    // Reset during the data bits of 0xFF with two bytes queued.
    do_reset;
    write_byte(8'hFF);
    t = cyc;
    write_byte(8'h12);
    write_byte(8'h34);
    while (cyc - t < 15) tick;
    chk("mr_busy_before", 32'(busy), 1);
    chk("mr_count_before", 32'(count), 2);
    reset = 1'b1;
    tick;
    chk("mr_txd", 32'(txd), 1);
    chk("mr_count", 32'(count), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_empty", 32'(empty), 1);
    reset = 1'b0;
    seen_low  = 0;
    seen_busy = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (txd !== 1'b1) seen_low++;
      if (busy !== 1'b0) seen_busy++;
    end
    chk("mr_no_txd_activity", 32'(seen_low), 0);
    chk("mr_no_busy", 32'(seen_busy), 0);
    write_byte(8'h3C);
    tw = cyc;
    rx_frame(b, s);
    chk("mr_after_byte", 32'(b), 32'h3C);
    chk("mr_after_latency", 32'(s - tw), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
